decode_pipe_unit: RTL

DECODE_PIPE_UNIT -- requirements
Module: decode_pipe_unit

---
 rtl/decode_pipe_unit_if.sv | 38 +++
 rtl/decode_pipe_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe_unit_if.sv
// Decode pipe handshake and control-bundle bundle.
// The master side feeds instructions and consumes the bundle. The slave side is the decode unit.
interface decode_pipe_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alu_select;
    logic        reg_write_en;
    logic [2:0]  data_mem_write;
    logic [3:0]  data_mem_read;
    logic [3:0]  branch_ctrl;
    logic [2:0]  immediate_select;
    logic        operand1_select;
    logic        operand2_select;
    logic [1:0]  writeback_value_select;
    logic [2:0]  csr_value_select;
    logic        illegal;
    logic        custom_busy;

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, alu_select, reg_write_en, data_mem_write,
               data_mem_read, branch_ctrl, immediate_select, operand1_select,
               operand2_select, writeback_value_select, csr_value_select,
               illegal, custom_busy
    );

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, alu_select, reg_write_en, data_mem_write,
               data_mem_read, branch_ctrl, immediate_select, operand1_select,
               operand2_select, writeback_value_select, csr_value_select,
               illegal, custom_busy
    );
endinterface

// File: rtl/decode_pipe_unit.sv
// Single-stage RV32 instruction decoder with a registered control bundle.
// The custom spike-send op is held for a programmable issue latency before
// its bundle is presented downstream.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_EMPTY  | no bundle held; ready to accept
// ST_FULL   | bundle valid downstream; accepts a new op when it is consumed
// ST_CUSTOM | custom op issuing; counter runs down to 0, then ST_FULL
module decode_pipe_unit #(
    parameter int          ENABLE_M      = 1,
    parameter int          ENABLE_CUSTOM = 1,
    parameter int unsigned CUSTOM_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    decode_pipe_unit_if.slave bus
);

    localparam logic       M_ON     = (ENABLE_M != 0);
    localparam logic       CUST_ON  = (ENABLE_CUSTOM != 0);
    localparam logic [3:0] CNT_INIT = 4'(CUSTOM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_CUSTOM = 2'd2
    } state_t;

    typedef struct packed {
        logic [5:0] alu_select;
        logic       reg_write_en;
        logic [2:0] data_mem_write;
        logic [3:0] data_mem_read;
        logic [3:0] branch_ctrl;
        logic [2:0] immediate_select;
        logic       operand1_select;
        logic       operand2_select;
        logic [1:0] writeback_value_select;
        logic [2:0] csr_value_select;
        logic       illegal;
    } ctrl_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    ctrl_t      dec;
    ctrl_t      ctrl_q;
    logic       in_ready_c;
    logic       accept;
    logic       load;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_opimm, is_op, is_system, is_zero, is_x3f, is_custom, is_m;
    logic known, ill, custom_go;
    logic unused_instr_bits;

    assign opcode = bus.instruction[6:0];
    assign f3     = bus.instruction[14:12];
    assign f7     = bus.instruction[31:25];

    // Register and immediate fields are consumed further down the pipe.
    assign unused_instr_bits = ^{bus.instruction[24:15], bus.instruction[11:7]};

    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_op     = (opcode == 7'b0110011);
    assign is_system = (opcode == 7'b1110011);
    assign is_zero   = (opcode == 7'b0000000);
    assign is_x3f    = (opcode == 7'b0111111);
    assign is_custom = (opcode == 7'b0101111);
    assign is_m      = is_op && (f7 == 7'b0000001);

    assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                   is_opimm | is_op | is_system | is_zero | is_x3f | is_custom;
    assign ill       = ~known | (is_m & ~M_ON) | (is_custom & ~CUST_ON);
    assign custom_go = is_custom & ~ill;

    // Combinational decode of the presented instruction word.
    always_comb begin
        dec = '0;
        dec.alu_select[2:0] = (is_auipc | is_jal | is_store | is_load | is_branch) ? 3'b000 : f3;
        dec.alu_select[3]   = is_m | is_lui;
        dec.alu_select[4]   = is_lui |
                              (bus.instruction[30] &
                               ((is_opimm & (f3 == 3'b101)) |
                                (is_op & ~is_m & ((f3 == 3'b000) | (f3 == 3'b101)))));
        dec.reg_write_en    = ~(is_store | is_branch | is_zero | is_custom | ill);
        dec.data_mem_write  = {is_store & ~ill, f3[1:0]};
        dec.data_mem_read   = {is_load & ~ill, f3};
        dec.branch_ctrl     = {(is_jal | is_jalr | is_branch) & ~ill,
                               (is_jal | is_jalr) ? 3'b010 : f3};
        if (is_jal)
            dec.immediate_select = 3'b001;
        else if (is_jalr | is_load | is_opimm | is_system | is_x3f)
            dec.immediate_select = 3'b010;
        else if (is_branch)
            dec.immediate_select = 3'b011;
        else if (is_store | is_custom)
            dec.immediate_select = 3'b100;
        else
            dec.immediate_select = 3'b000;
        dec.operand1_select = is_auipc | is_jal | is_branch;
        dec.operand2_select = is_load | is_opimm | is_auipc | is_store | is_lui |
                              is_jalr | is_jal | is_branch;
        if (is_jal | is_jalr)
            dec.writeback_value_select = 2'b00;
        else if (is_load)
            dec.writeback_value_select = 2'b01;
        else
            dec.writeback_value_select = 2'b10;
        dec.csr_value_select = f3;
        dec.illegal          = ill;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_EMPTY;
        else
            state <= state_nxt;
    end

    // Handshake and next-state selection; flush overrides everything.
    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_EMPTY: begin
                in_ready_c = 1'b1;
            end
            ST_FULL: begin
                in_ready_c = bus.out_ready;
            end
            default: begin
                in_ready_c = 1'b0;
            end
        endcase
        if (bus.flush)
            in_ready_c = 1'b0;
        accept = bus.in_valid & in_ready_c;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = custom_go ? ST_CUSTOM : ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        load      = 1'b1;
                        state_nxt = custom_go ? ST_CUSTOM : ST_FULL;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            ST_CUSTOM: begin
                if (cnt == 4'd0)
                    state_nxt = ST_FULL;
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
        if (bus.flush) begin
            load      = 1'b0;
            state_nxt = ST_EMPTY;
        end
    end

    // Custom-op issue counter: loaded on acceptance, runs down while issuing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= 4'd0;
        else if (bus.flush)
            cnt <= 4'd0;
        else if (load)
            cnt <= custom_go ? CNT_INIT : 4'd0;
        else if (state == ST_CUSTOM && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    // Control bundle register, captured only on acceptance so it holds under backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ctrl_q <= '0;
        else if (load)
            ctrl_q <= dec;
    end

    assign bus.in_ready               = in_ready_c;
    assign bus.out_valid              = (state == ST_FULL);
    assign bus.custom_busy            = (state == ST_CUSTOM);
    assign bus.alu_select             = ctrl_q.alu_select;
    assign bus.reg_write_en           = ctrl_q.reg_write_en;
    assign bus.data_mem_write         = ctrl_q.data_mem_write;
    assign bus.data_mem_read          = ctrl_q.data_mem_read;
    assign bus.branch_ctrl            = ctrl_q.branch_ctrl;
    assign bus.immediate_select       = ctrl_q.immediate_select;
    assign bus.operand1_select        = ctrl_q.operand1_select;
    assign bus.operand2_select        = ctrl_q.operand2_select;
    assign bus.writeback_value_select = ctrl_q.writeback_value_select;
    assign bus.csr_value_select       = ctrl_q.csr_value_select;
    assign bus.illegal                = ctrl_q.illegal;

endmodule
